// File: rtl/fp16_group_accumulator.sv
// Sums a variable-length group of FP16 terms in a wide fixed-point register (units of 2^-24).
// Rounds once to FP16 (nearest-even, flush-to-zero, saturate to infinity) when the group closes.
module fp16_group_accumulator #(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = $clog2(MAX_LEN) + 1,
    parameter int ACC_W   = 42 + $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_fp16,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_fp16,
    output logic [CNT_W-1:0] out_len
);

    localparam int LW = $clog2(ACC_W);

    typedef enum logic {ACC, OUT} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]         cnt;
    logic                     nan_flag;

    logic [ACC_W-1:0]         mag_in;
    logic signed [ACC_W-1:0]  term;
    logic                     term_nan;
    logic signed [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]         mag;
    logic [ACC_W-1:0]         norm;
    logic [LW-1:0]            lead;
    logic [LW-1:0]            exp_pre;
    logic [LW:0]              exp_fin;
    logic [9:0]               frac_r;
    logic [10:0]              frac_up;
    logic                     guard;
    logic                     sticky;
    logic [15:0]              rounded;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     closing;

    assign in_ready = (state == ACC);
    assign cnt_inc  = cnt + 1'b1;
    assign closing  = in_last || (cnt_inc == CNT_W'(MAX_LEN));

    always_comb begin
        mag_in   = '0;
        term     = '0;
        term_nan = 1'b0;
        if (in_fp16[14:10] == 5'h1F) begin
            term_nan = 1'b1;
        end else if (in_fp16[14:10] != 5'h00) begin
            mag_in = {{(ACC_W-11){1'b0}}, 1'b1, in_fp16[9:0]} << (in_fp16[14:10] - 5'd1);
            term   = in_fp16[15] ? -$signed(mag_in) : $signed(mag_in);
        end
    end

    // Left-justify the magnitude so frac/guard/sticky sit at fixed bit positions;
    // zero fill from the shift supplies the "bits below index 0 read as 0" case.
    always_comb begin
        sum  = acc + term;
        mag  = sum[ACC_W-1] ? ACC_W'(-sum) : ACC_W'(sum);
        lead = '0;
        for (int unsigned i = 0; i < ACC_W; i++) begin
            if (mag[i]) lead = i[LW-1:0];
        end
        norm    = mag << (LW'(ACC_W - 1) - lead);
        frac_r  = norm[ACC_W-2 -: 10];
        guard   = norm[ACC_W-12];
        sticky  = |norm[ACC_W-13:0];
        frac_up = {1'b0, frac_r} + 11'(guard && (sticky || frac_r[0]));
        exp_pre = lead - LW'(9);
        exp_fin = {1'b0, exp_pre} + (LW+1)'(frac_up[10]);

        if (nan_flag || term_nan)
            rounded = 16'h7E00;
        else if (mag == '0 || lead <= LW'(9))
            rounded = 16'h0000;
        else if (exp_fin >= (LW+1)'(31))
            rounded = {sum[ACC_W-1], 5'h1F, 10'h000};
        else
            rounded = {sum[ACC_W-1], exp_fin[4:0], frac_up[9:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            nan_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_fp16  <= 16'h0000;
            out_len   <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        acc      <= sum;
                        cnt      <= cnt_inc;
                        nan_flag <= nan_flag | term_nan;
                        if (closing) begin
                            state     <= OUT;
                            out_valid <= 1'b1;
                            out_fp16  <= rounded;
                            out_len   <= cnt_inc;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= ACC;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        cnt       <= '0;
                        nan_flag  <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_fp16_group_accumulator.sv
// Directed-vector bench for fp16_group_accumulator with hand-computed FP16 group sums.
module tb_fp16_group_accumulator;

    localparam int MAX_LEN = 256;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;
    localparam int ACC_W   = 42 + $clog2(MAX_LEN);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [15:0]      in_fp16 = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [15:0]      out_fp16;
    logic [CNT_W-1:0] out_len;

    int vectors = 0;
    int miscompares = 0;

    fp16_group_accumulator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fp16   (in_fp16),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp16  (out_fp16),
        .out_len   (out_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one term and returns 1 time unit after the edge that accepted it.
    task automatic push(input logic [15:0] v, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_fp16  = v;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) check("push_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [15:0] ef, input int el);
        int n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_fp16"}, 32'(out_fp16), 32'(ef));
        check({tag, "_len"}, 32'(out_len), 32'(el));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_fp16", 32'(out_fp16), 32'h0);
        check("rst_len", 32'(out_len), 32'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);

        // basic sum and one-cycle latency
        push(16'h3C00, 1'b0);
        check("t1_early", 32'(out_valid), 32'd0);
        push(16'h4000, 1'b1);
        check("t1_lat", 32'(out_valid), 32'd1);
        check("t1_busy", 32'(in_ready), 32'd0);
        get_result("t1", 16'h4200, 2);

        // cancellation yields +0; in_last without in_valid is ignored
        push(16'h3C00, 1'b0);
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        check("t2_ign", 32'(out_valid), 32'd0);
        push(16'hBC00, 1'b1);
        get_result("t2a", 16'h0000, 2);
        for (int i = 0; i < 4; i++) push(16'h0000, i == 3);
        get_result("t2b", 16'h0000, 4);

        // rounding
        push(16'h3C00, 1'b0);
        push(16'h1000, 1'b1);
        get_result("t3tie", 16'h3C00, 2);
        push(16'h3C00, 1'b0);
        for (int i = 0; i < 3; i++) push(16'h1000, i == 2);
        get_result("t3up", 16'h3C02, 4);
        push(16'h3C00, 1'b0);
        push(16'h1400, 1'b1);
        get_result("t3ex", 16'h3C01, 2);

        // range and specials
        push(16'h7BFF, 1'b0);
        push(16'h7BFF, 1'b1);
        get_result("t4inf", 16'h7C00, 2);
        push(16'hFBFF, 1'b0);
        push(16'hFBFF, 1'b1);
        get_result("t4ninf", 16'hFC00, 2);
        push(16'h0600, 1'b0);
        push(16'h8400, 1'b1);
        get_result("t4ftz", 16'h0000, 2);
        push(16'h3C00, 1'b0);
        push(16'h7C00, 1'b0);
        push(16'h3C00, 1'b1);
        get_result("t4nan", 16'h7E00, 3);
        push(16'h3C00, 1'b0);
        push(16'h7C00, 1'b1);
        get_result("t4nanl", 16'h7E00, 2);

        // forced close at MAX_LEN
        for (int i = 0; i < MAX_LEN - 1; i++) push(16'h3C00, 1'b0);
        check("t5_open", 32'(out_valid), 32'd0);
        push(16'h3C00, 1'b0);
        check("t5_lat", 32'(out_valid), 32'd1);
        get_result("t5", 16'h5C00, MAX_LEN);
        push(16'h4000, 1'b1);
        get_result("t5nxt", 16'h4000, 1);

        // backpressure: output holds, input stalls
        push(16'h3C00, 1'b0);
        push(16'h3C00, 1'b1);
        in_valid = 1'b1;
        in_fp16  = 16'h4000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_fp16", 32'(out_fp16), 32'h4000);
            check("t6_len", 32'(out_len), 32'd2);
            check("t6_rdy", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        get_result("t6", 16'h4000, 2);
        push(16'h3C00, 1'b1);
        get_result("t6nxt", 16'h3C00, 1);

        // reset mid-group discards state
        for (int i = 0; i < 3; i++) push(16'h3C00, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("t7_valid", 32'(out_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_rdy", 32'(in_ready), 32'd1);
        push(16'h4000, 1'b1);
        get_result("t7", 16'h4000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
